weighted_arbiter: RTL
=====================

Name: weighted_arbiter

Overview:
- Parametrised successor to the basic request/acknowledge arbiter.
- Grants one of PORTS requesters, but holds the grant for up to a per-port weight of acknowledged transfers before rotating.
- Provides weighted round-robin or quota-limited priority arbitration for AXI interconnect address and data channel muxing.
- Outputs are registered; there is no combinational path from request to grant.

Parameters:
- PORTS, 4: number of requesters; legal range 2..32.
- TYPE, "ROUND_ROBIN": "ROUND_ROBIN" or "PRIORITY".
- LSB_PRIORITY, "LOW": "LOW" means index 0 has highest base priority; "HIGH" means index PORTS-1 does.
- WEIGHT_W, 4: width of each per-port weight and of the credit counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- request  in  PORTS  per-port request level.
- acknowledge  in  PORTS  per-port transfer-complete strobe.
- weight  in  PORTS*WEIGHT_W  per-port quota, port i at [i*WEIGHT_W +: WEIGHT_W]; value 0 is treated as 1.
- grant  out  PORTS  one-hot grant, or all zero.
- grant_valid  out  1  high iff grant is nonzero.
- grant_encoded  out  $clog2(PORTS)  binary index of the granted port; 0 when grant_valid is low.
- credit  out  WEIGHT_W  remaining acknowledges for the current holder; 0 when idle.

Behaviour:
- Reset (rst_n low at an edge):
  - grant=0, grant_valid=0, grant_encoded=0, credit=0.
  - Rotation pointer set to the highest-priority index: 0 for LOW, PORTS-1 for HIGH.
  - Reset overrides any in-progress grant; no release pulse is produced.
- States:
  - IDLE: grant_valid=0.
  - HOLD(h): grant=1<<h.
- IDLE -> HOLD(w):
  - At the edge where request is nonzero; w is the arbitration winner.
  - Latency is one cycle from request to grant.
  - credit loads max(weight[w],1) at the same edge.
- In HOLD(h), an acknowledge event is acknowledge[h] and request[h]. acknowledge bits of non-granted ports are ignored.
- Release condition in HOLD(h): request[h] low, OR an acknowledge event while credit==1.
- Acknowledge event with credit>1: credit decrements by 1; grant is unchanged.
- On release: re-arbitrate at the same edge over the current request vector, excluding h on quota exhaustion only.
  - If another port wins, go to HOLD(new) with no idle bubble.
  - If no port is eligible, go to IDLE.
  - On quota exhaustion with no other requester, h is re-granted with reloaded credit (back-to-back). grant stays high and credit reloads.
- ROUND_ROBIN:
  - Search starts at the port after the last released holder and wraps modulo PORTS.
  - Direction: ascending for LOW, descending for HIGH.
  - The pointer updates only on release.
- PRIORITY:
  - Fixed order per LSB_PRIORITY.
  - A quota-exhausted holder is masked for exactly one arbitration if any other port requests.
- Weight sampling: the weight is sampled only when credit loads; changes mid-hold have no effect.
- Simultaneous events:
  - request[h] falling together with acknowledge[h] counts as a release, not a credit decrement.
  - Requests arriving during HOLD never preempt the holder.
- Invariants: grant is one-hot or zero; grant_valid == |grant; (1<<grant_encoded)==grant when valid; credit is never 0 in HOLD.

Decomposition:
- Package arbiter_pkg:
  - TYPE and LSB_PRIORITY string constants.
  - A localparam function for the encoded width (clog2 with minimum 1).
- One combinational sub-module, rr_mask_select (PORTS, LSB_PRIORITY):
  - Inputs: request vector, exclude mask, start pointer.
  - Outputs: winner one-hot, winner index, valid.
  - Implemented as masked find-first plus an unmasked fallback for wrap-around.
- State, credit counter and pointer live in weighted_arbiter.

Test Plan:
- Reset mid-hold: PORTS=4, grant on port 2 with credit 3, rst_n=0 for 1 cycle -> next cycle grant=0, credit=0; with request=4'b0101, the first grant after reset is port 0 (LOW).
- Weighted rotation: ROUND_ROBIN, weights {1,2,3,1} for ports 0..3, all ports request, acknowledge every cycle -> grant sequence 0,1,1,2,2,2,3,0 with no idle cycles.
- Early drop: port 1 granted with weight 5, request[1] falls after 2 acknowledges -> grant moves to port 2 at the next edge; credit loads weight[2].
- Sole requester: only port 3 requests with weight 2 and acknowledge is held high -> grant_valid stays 1 continuously; credit cycles 2,1,2,1.
- PRIORITY quota: LOW, ports 0 and 2 request, weight[0]=2 -> port 0 gets 2 acknowledges, port 2 then gets 1 grant window, then port 0 returns.
- Weight zero and ignored acks: weight[1]=0 -> treated as 1, releasing after a single acknowledge; acknowledge[0] pulsed while port 1 is granted -> no effect on credit or grant.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared constants and helpers for the weighted arbiter.
// Selects arbitration type / base priority and sizes the encoded index.
package arbiter_pkg;

  localparam string TYPE_RR  = "ROUND_ROBIN";
  localparam string TYPE_PRI = "PRIORITY";
  localparam string LSB_LOW  = "LOW";
  localparam string LSB_HIGH = "HIGH";

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Index width, never below one bit.
  function automatic int enc_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mask_select.sv
// Rotating find-first: request & ~exclude, searched from start.
// Ports: request, exclude, start in; winner (one-hot), winner_idx, valid out.
module rr_mask_select
  import arbiter_pkg::*;
#(
  parameter int    PORTS        = 4,
  parameter string LSB_PRIORITY = "LOW",
  localparam int   IW           = enc_w(PORTS)
) (
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] exclude,
  input  logic [IW-1:0]    start,
  output logic [PORTS-1:0] winner,
  output logic [IW-1:0]    winner_idx,
  output logic             valid
);

  localparam bit HI = (LSB_PRIORITY == "HIGH");

  logic [PORTS-1:0] elig;
  logic [PORTS-1:0] in_win;
  logic [PORTS-1:0] masked;
  logic [PORTS-1:0] pick;

  always_comb begin
    elig = request & ~exclude;
    for (int i = 0; i < PORTS; i++) begin
      in_win[i] = HI ? (i <= int'(start))
                     : (i >= int'(start));
    end
    masked = elig & in_win;
    // Nothing at or past start: wrap to the unmasked set.
    pick = (|masked) ? masked : elig;
    winner_idx = '0;
    if (HI) begin
      for (int i = 0; i < PORTS; i++)
        if (pick[i]) winner_idx = IW'(i);
    end else begin
      for (int i = PORTS - 1; i >= 0; i--)
        if (pick[i]) winner_idx = IW'(i);
    end
    valid  = |elig;
    winner = valid ? (PORTS'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/weighted_arbiter.sv
// Weighted round-robin / quota-limited priority arbiter, registered outputs.
// Ports: clk, rst_n, request, acknowledge, weight in; grant, grant_valid, grant_encoded, credit out.
module weighted_arbiter
  import arbiter_pkg::*;
#(
  parameter int    PORTS        = 4,
  parameter string TYPE         = "ROUND_ROBIN",
  parameter string LSB_PRIORITY = "LOW",
  parameter int    WEIGHT_W     = 4,
  localparam int   IW           = enc_w(PORTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORTS-1:0]          request,
  input  logic [PORTS-1:0]          acknowledge,
  input  logic [PORTS*WEIGHT_W-1:0] weight,
  output logic [PORTS-1:0]          grant,
  output logic                      grant_valid,
  output logic [IW-1:0]             grant_encoded,
  output logic [WEIGHT_W-1:0]       credit
);

  localparam bit HI  = (LSB_PRIORITY == "HIGH");
  localparam bit PRI = (TYPE == "PRIORITY");
  localparam logic [IW-1:0] LAST = IW'(PORTS - 1);
  localparam logic [IW-1:0] BASE = HI ? LAST : '0;

  arb_state_t state;
  logic [IW-1:0] ptr;

  logic [WEIGHT_W-1:0] w_arr [PORTS];
  logic                hold;
  logic                req_h;
  logic                ack_ev;
  logic                exhaust;
  logic                rel;
  logic [IW-1:0]       nxt_h;
  logic [IW-1:0]       start;
  logic [PORTS-1:0]    excl;
  logic [WEIGHT_W-1:0] load_w;
  logic [WEIGHT_W-1:0] hold_w;

  logic [PORTS-1:0]    sel_oh;
  logic [IW-1:0]       sel_idx;
  logic                sel_v;

  always_comb begin
    for (int i = 0; i < PORTS; i++)
      w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    hold    = (state == HOLD);
    req_h   = request[grant_encoded];
    ack_ev  = hold & acknowledge[grant_encoded] & req_h;
    exhaust = ack_ev & (credit == WEIGHT_W'(1));
    // A dropped request wins over a coincident ack.
    rel     = hold & (~req_h | exhaust);
    if (HI)
      nxt_h = (grant_encoded == '0) ? LAST : grant_encoded - 1'b1;
    else
      nxt_h = (grant_encoded == LAST) ? '0 : grant_encoded + 1'b1;
    // Rotation resumes just past the holder being released.
    start   = PRI ? BASE : (rel ? nxt_h : ptr);
    // Holder sits out one round only when its quota ran out.
    excl    = exhaust ? grant : '0;
    load_w  = w_arr[sel_idx];
    if (load_w == '0) load_w = WEIGHT_W'(1);
    hold_w  = w_arr[grant_encoded];
    if (hold_w == '0) hold_w = WEIGHT_W'(1);
  end

  rr_mask_select #(
    .PORTS        (PORTS),
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_sel (
    .request    (request),
    .exclude    (excl),
    .start      (start),
    .winner     (sel_oh),
    .winner_idx (sel_idx),
    .valid      (sel_v)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      credit        <= '0;
      ptr           <= BASE;
    end else if (!hold || rel) begin
      if (rel) ptr <= nxt_h;
      if (sel_v) begin
        state         <= HOLD;
        grant         <= sel_oh;
        grant_valid   <= 1'b1;
        grant_encoded <= sel_idx;
        credit        <= load_w;
      end else if (exhaust) begin
        // Sole requester: re-grant with a fresh quota.
        credit <= hold_w;
      end else begin
        state         <= IDLE;
        grant         <= '0;
        grant_valid   <= 1'b0;
        grant_encoded <= '0;
        credit        <= '0;
      end
    end else if (ack_ev) begin
      credit <= credit - 1'b1;
    end
  end

endmodule
